// File: rtl/layer_sched_pkg.sv
// Shared types and constants for the VGA layer priority scheduler.
// Holds the layer count, the layer index encoding, the blink FSM state
// type, the priority-table entry layout and the power-up priority table.
package layer_sched_pkg;

  localparam int NUM_LAYERS  = 5;
  localparam int LAYER_IDX_W = 3;

  typedef enum logic [LAYER_IDX_W-1:0] {
    LYR_BLACK    = 3'd0,
    LYR_PLAYER   = 3'd1,
    LYR_ROADCARS = 3'd2,
    LYR_ROAD     = 3'd3,
    LYR_VALUES   = 3'd4,
    LYR_BG       = 3'd5
  } layer_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIDE = 2'd1,
    SHOW = 2'd2
  } blink_state_t;

  typedef struct packed {
    logic [2:0] prio;
    logic       en;
  } prio_entry_t;

  typedef prio_entry_t [NUM_LAYERS-1:0] prio_tbl_t;

  // prio[i] = i with every layer enabled: black > player > roadcars > road > values.
  localparam prio_tbl_t DEFAULT_TBL = {4'b1001, 4'b0111, 4'b0101, 4'b0011, 4'b0001};

endpackage

// File: rtl/layer_blink_fsm.sv
// Crash-blink sequencer. A blinkStart pulse (re)starts a sequence that
// alternates HIDE/SHOW on every startOfFrame until BLINK_TOGGLES frame
// boundaries have passed, then returns to IDLE.
// Ports:
//   clk, resetN          - pixel clock, asynchronous active-low reset
//   startOfFrame         - frame-boundary pulse
//   blinkStart           - start/restart pulse (wins over startOfFrame)
//   blinkHide            - high while the blinked layer must be masked
//   blinkActive          - high whenever the sequencer is not IDLE
module layer_blink_fsm
  import layer_sched_pkg::*;
#(
  parameter int BLINK_TOGGLES = 8
) (
  input  logic clk,
  input  logic resetN,
  input  logic startOfFrame,
  input  logic blinkStart,
  output logic blinkHide,
  output logic blinkActive
);

  localparam int CNT_W = $clog2(BLINK_TOGGLES + 1);

  blink_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + CNT_W'(1);
    case (state_q)
      IDLE: begin
        if (blinkStart) begin
          state_d = HIDE;
          cnt_d   = '0;
        end
      end
      HIDE, SHOW: begin
        if (blinkStart) begin
          state_d = HIDE;
          cnt_d   = '0;
        end else if (startOfFrame) begin
          if (cnt_inc == CNT_W'(BLINK_TOGGLES)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = (state_q == HIDE) ? SHOW : HIDE;
            cnt_d   = cnt_inc;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign blinkHide   = (state_q == HIDE);
  assign blinkActive = (state_q != IDLE);

endmodule

// File: rtl/layer_priority_sched.sv
// Frame-synchronised priority scheduler for the VGA object layers.
// Each pixel, the requesting enabled layer with the lowest priority value
// wins (ties to the lowest index); with no request the background wins.
// Priority/enable writes land in a shadow table that is copied to the
// active table on startOfFrame, so a frame never mixes two tables.
// Two-cycle pipeline: stage 1 masks requests, stage 2 picks the winner.
// Ports:
//   clk, resetN                 - pixel clock, asynchronous active-low reset
//   startOfFrame                - first-pixel pulse; commits the shadow table
//   cfgWrite/cfgLayer/cfgPrio/cfgEnable, cfgReady - config write handshake
//   reqVec, rgbVec, bgRGB       - per-layer requests/colours, background colour
//   blinkStart, blinkActive     - crash-blink control/status
//   RGBOut, winLayer            - final colour and winning layer (5 = background)
//   playerPixCount              - pixels won by the blink layer last frame
// Optional build macro LAYER_SCHED_PIXCOUNT_EN enables playerPixCount;
// otherwise it is tied to zero.
module layer_priority_sched
  import layer_sched_pkg::*;
#(
  parameter int RGB_W         = 8,
  parameter int BLINK_LAYER   = 1,
  parameter int BLINK_TOGGLES = 8
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        startOfFrame,
  input  logic                        cfgWrite,
  input  logic [LAYER_IDX_W-1:0]      cfgLayer,
  input  logic [2:0]                  cfgPrio,
  input  logic                        cfgEnable,
  output logic                        cfgReady,
  input  logic [NUM_LAYERS-1:0]       reqVec,
  input  logic [NUM_LAYERS*RGB_W-1:0] rgbVec,
  input  logic [RGB_W-1:0]            bgRGB,
  input  logic                        blinkStart,
  output logic [RGB_W-1:0]            RGBOut,
  output logic [LAYER_IDX_W-1:0]      winLayer,
  output logic                        blinkActive,
  output logic [16:0]                 playerPixCount
);

  logic blink_hide;

  layer_blink_fsm #(.BLINK_TOGGLES(BLINK_TOGGLES)) u_blink (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .blinkStart   (blinkStart),
    .blinkHide    (blink_hide),
    .blinkActive  (blinkActive)
  );

  // Writes are refused on the commit cycle so a write can never race the copy.
  assign cfgReady = !startOfFrame;

  prio_tbl_t shadow_q, shadow_d, active_q, active_d;

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (startOfFrame) active_d = shadow_q;
    if (cfgWrite && cfgReady) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (cfgLayer == i[LAYER_IDX_W-1:0]) begin
          shadow_d[i].prio = cfgPrio;
          shadow_d[i].en   = cfgEnable;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      shadow_q <= DEFAULT_TBL;
      active_q <= DEFAULT_TBL;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  // ---- stage 1: mask requests, carry colours and priorities ----
  logic [NUM_LAYERS-1:0]       req_p1_d, req_p1_q;
  logic [NUM_LAYERS-1:0][2:0]  prio_p1_d, prio_p1_q;
  logic [NUM_LAYERS*RGB_W-1:0] rgb_p1_d, rgb_p1_q;
  logic [RGB_W-1:0]            bg_p1_d, bg_p1_q;

  always_comb begin
    req_p1_d  = '0;
    prio_p1_d = '0;
    rgb_p1_d  = rgbVec;
    bg_p1_d   = bgRGB;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      req_p1_d[i]  = reqVec[i] && active_q[i].en && !(blink_hide && (i == BLINK_LAYER));
      prio_p1_d[i] = active_q[i].prio;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) req_p1_q <= '0;
    else         req_p1_q <= req_p1_d;
  end

  always_ff @(posedge clk) begin
    prio_p1_q <= prio_p1_d;
    rgb_p1_q  <= rgb_p1_d;
    bg_p1_q   <= bg_p1_d;
  end

  // ---- stage 2: lowest priority wins, strict compare keeps lowest index on ties ----
  logic [LAYER_IDX_W-1:0] win_p2_d, win_p2_q;
  logic [RGB_W-1:0]       rgb_p2_d, rgb_p2_q;
  logic                   found;
  logic [2:0]             best_prio;

  always_comb begin
    found     = 1'b0;
    best_prio = '1;
    win_p2_d  = LYR_BG;
    rgb_p2_d  = bg_p1_q;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (req_p1_q[i] && (!found || (prio_p1_q[i] < best_prio))) begin
        found     = 1'b1;
        best_prio = prio_p1_q[i];
        win_p2_d  = i[LAYER_IDX_W-1:0];
        rgb_p2_d  = rgb_p1_q[i*RGB_W +: RGB_W];
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      win_p2_q <= LYR_BG;
      rgb_p2_q <= '0;
    end else begin
      win_p2_q <= win_p2_d;
      rgb_p2_q <= rgb_p2_d;
    end
  end

  assign RGBOut   = rgb_p2_q;
  assign winLayer = win_p2_q;

`ifdef LAYER_SCHED_PIXCOUNT_EN
  localparam logic [LAYER_IDX_W-1:0] BLINK_IDX = LAYER_IDX_W'(BLINK_LAYER);

  logic [16:0] pix_cnt_q, pix_cnt_d, pix_out_q, pix_out_d, pix_inc;

  // The frame-boundary cycle's own hit is folded into the reported total.
  always_comb begin
    pix_inc = pix_cnt_q;
    if ((win_p2_d == BLINK_IDX) && (pix_cnt_q != 17'h1FFFF)) pix_inc = pix_cnt_q + 17'd1;
    pix_cnt_d = pix_inc;
    pix_out_d = pix_out_q;
    if (startOfFrame) begin
      pix_out_d = pix_inc;
      pix_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pix_cnt_q <= '0;
      pix_out_q <= '0;
    end else begin
      pix_cnt_q <= pix_cnt_d;
      pix_out_q <= pix_out_d;
    end
  end

  assign playerPixCount = pix_out_q;
`else
  assign playerPixCount = '0;
`endif

endmodule

// File: tb/tb_layer_priority_sched.sv
module tb_layer_priority_sched;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic        startOfFrame = 1'b0;
  logic        cfgWrite = 1'b0;
  logic [2:0]  cfgLayer = '0;
  logic [2:0]  cfgPrio = '0;
  logic        cfgEnable = 1'b0;
  logic        cfgReady;
  logic [4:0]  reqVec = '0;
  logic [39:0] rgbVec = '0;
  logic [7:0]  bgRGB = '0;
  logic        blinkStart = 1'b0;
  logic [7:0]  RGBOut;
  logic [2:0]  winLayer;
  logic        blinkActive;
  logic [16:0] playerPixCount;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  layer_priority_sched dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .cfgWrite       (cfgWrite),
    .cfgLayer       (cfgLayer),
    .cfgPrio        (cfgPrio),
    .cfgEnable      (cfgEnable),
    .cfgReady       (cfgReady),
    .reqVec         (reqVec),
    .rgbVec         (rgbVec),
    .bgRGB          (bgRGB),
    .blinkStart     (blinkStart),
    .RGBOut         (RGBOut),
    .winLayer       (winLayer),
    .blinkActive    (blinkActive),
    .playerPixCount (playerPixCount)
  );

  typedef struct {
    logic [4:0] req;
    logic [7:0] exp_rgb;
    logic [2:0] exp_win;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_px(input string name, input logic [7:0] rgb, input logic [2:0] win);
    chk({name, "_rgb"}, 32'(RGBOut), 32'(rgb));
    chk({name, "_win"}, 32'(winLayer), 32'(win));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic sof();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic wr(input logic [2:0] l, input logic [2:0] p, input logic e);
    cfgLayer  = l;
    cfgPrio   = p;
    cfgEnable = e;
    cfgWrite  = 1'b1;
    tick();
    cfgWrite  = 1'b0;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    tick();
  endtask

  task automatic blink_pulse();
    blinkStart = 1'b1;
    tick();
    blinkStart = 1'b0;
  endtask

  initial begin
    // layer0..4 colours: 11, 1C, E0, 33, 44; background 49
    rgbVec  = {8'h44, 8'h33, 8'hE0, 8'h1C, 8'h11};
    bgRGB   = 8'h49;
    vecs[0] = '{5'b00110, 8'h1C, 3'd1};
    vecs[1] = '{5'b00000, 8'h49, 3'd5};
    vecs[2] = '{5'b11111, 8'h11, 3'd0};
    vecs[3] = '{5'b11000, 8'h33, 3'd3};
    vecs[4] = '{5'b10000, 8'h44, 3'd4};
    vecs[5] = '{5'b00100, 8'hE0, 3'd2};
    vecs[6] = '{5'b01010, 8'h1C, 3'd1};

    // Reset state
    #1 resetN = 1'b0;
    #1;
    chk("rst_rgb",    32'(RGBOut), 32'h00);
    chk("rst_win",    32'(winLayer), 32'd5);
    chk("rst_blink",  32'(blinkActive), 32'd0);
    chk("rst_ready",  32'(cfgReady), 32'd1);
    chk("rst_pixcnt", 32'(playerPixCount), 32'd0);
    tick();
    resetN = 1'b1;
    tick();

    // Default-table vectors
    for (int i = 0; i < 7; i++) begin
      reqVec = vecs[i].req;
      ticks(2);
      chk_px($sformatf("vec%0d", i), vecs[i].exp_rgb, vecs[i].exp_win);
    end

    // Exact two-cycle latency
    reqVec = 5'b00110;
    ticks(2);
    reqVec = 5'b00100;
    tick();
    chk_px("lat1", 8'h1C, 3'd1);
    tick();
    chk_px("lat2", 8'hE0, 3'd2);

    // Mid-frame write is shadowed until the frame boundary
    do_reset();
    reqVec = 5'b00110;
    ticks(2);
    wr(3'd2, 3'd0, 1'b1);
    ticks(3);
    chk_px("midframe", 8'h1C, 3'd1);
    sof();
    chk_px("sof_p0", 8'h1C, 3'd1);
    tick();
    chk_px("sof_p1", 8'h1C, 3'd1);
    tick();
    chk_px("commit", 8'hE0, 3'd2);

    // Write presented on a startOfFrame cycle is refused
    do_reset();
    reqVec = 5'b00110;
    startOfFrame = 1'b1;
    cfgLayer = 3'd2; cfgPrio = 3'd0; cfgEnable = 1'b1; cfgWrite = 1'b1;
    #1;
    chk("ready_sof", 32'(cfgReady), 32'd0);
    tick();
    startOfFrame = 1'b0;
    cfgWrite = 1'b0;
    #1;
    chk("ready_after", 32'(cfgReady), 32'd1);
    ticks(3);
    sof();
    ticks(2);
    chk_px("dropped", 8'h1C, 3'd1);
    // Held write: refused on the SOF cycle, accepted on the next one
    startOfFrame = 1'b1;
    cfgWrite = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
    cfgWrite = 1'b0;
    ticks(2);
    chk_px("old_shadow", 8'h1C, 3'd1);
    ticks(2);
    sof();
    ticks(2);
    chk_px("held_commit", 8'hE0, 3'd2);

    // All layers disabled, then ties and reordering
    do_reset();
    for (int l = 0; l < 5; l++) wr(3'(l), 3'(l), 1'b0);
    reqVec = 5'b11111;
    sof();
    ticks(2);
    chk_px("all_off", 8'h49, 3'd5);
    wr(3'd3, 3'd3, 1'b1);
    wr(3'd4, 3'd3, 1'b1);
    sof();
    ticks(2);
    chk_px("tie", 8'h33, 3'd3);
    wr(3'd4, 3'd2, 1'b1);
    sof();
    ticks(2);
    chk_px("prio_swap", 8'h44, 3'd4);

    // Blink sequence: hidden on frames 1,3,5,7; idle after the 8th toggle
    do_reset();
    reqVec = 5'b00010;
    blink_pulse();
    for (int f = 1; f <= 10; f++) begin
      logic hidden;
      hidden = (f <= 7) && (f % 2 == 1);
      ticks(3);
      chk_px($sformatf("blink_f%0d", f), hidden ? 8'h49 : 8'h1C, hidden ? 3'd5 : 3'd1);
      chk($sformatf("blink_act_f%0d", f), 32'(blinkActive), (f <= 8) ? 32'd1 : 32'd0);
      sof();
    end

    // blinkStart beats a simultaneous startOfFrame
    do_reset();
    blink_pulse();
    ticks(2);
    startOfFrame = 1'b1;
    blinkStart = 1'b1;
    tick();
    startOfFrame = 1'b0;
    blinkStart = 1'b0;
    ticks(3);
    chk_px("start_prio", 8'h49, 3'd5);

    // Restart in frame 4 needs a full new set of toggles
    do_reset();
    blink_pulse();
    for (int f = 0; f < 3; f++) begin
      ticks(2);
      sof();
    end
    ticks(2);
    blink_pulse();
    ticks(3);
    chk_px("restart_hide", 8'h49, 3'd5);
    for (int f = 0; f < 7; f++) begin
      ticks(2);
      sof();
    end
    chk("restart_active", 32'(blinkActive), 32'd1);
    ticks(1);
    sof();
    ticks(1);
    chk("restart_done", 32'(blinkActive), 32'd0);

    // Reset in the middle of a blink
    blink_pulse();
    ticks(3);
    resetN = 1'b0;
    #1;
    chk("midrst_blink", 32'(blinkActive), 32'd0);
    chk("midrst_rgb", 32'(RGBOut), 32'h00);
    chk("midrst_win", 32'(winLayer), 32'd5);
    tick();
    resetN = 1'b1;
    tick();

    // Player pixel count over a 300-pixel run
    reqVec = 5'b00000;
    ticks(2);
    sof();
    reqVec = 5'b00010;
    ticks(300);
    reqVec = 5'b00000;
    ticks(2);
    sof();
`ifdef LAYER_SCHED_PIXCOUNT_EN
    chk("pixcount", 32'(playerPixCount), 32'd300);
`else
    chk("pixcount", 32'(playerPixCount), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/layer_priority_sched.md
Name: layer_priority_sched

Overview:
- Programmable, frame-synchronised priority scheduler for the VGA object layers: black squares, player, road cars, road, values, plus background MIF.
- Per pixel, picks the winning layer from per-layer requests, a runtime-configurable priority table and enable mask; drives the final RGB to the VGA controller.
- Config writes are shadowed and committed only at start of frame, so no tearing mid-frame.
- Contains a crash-blink sequencer that masks the player layer on alternate frames.

Parameters:
NUM_LAYERS, 5, number of requesting layers (index 0..4; background is implicit index 5)
RGB_W, 8, pixel colour width
BLINK_LAYER, 1, layer index hidden during blink (player)
BLINK_TOGGLES, 8, number of frame-boundary toggles in one blink sequence

Ports:
clk  in  1  pixel clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-cycle pulse at the first pixel of each frame
cfgWrite  in  1  config write request; accepted only when cfgReady=1
cfgLayer  in  3  layer index being configured (values >= NUM_LAYERS are ignored)
cfgPrio  in  3  priority for that layer; 0 = highest
cfgEnable  in  1  layer enable
cfgReady  out  1  config handshake ready
reqVec  in  NUM_LAYERS  per-layer draw requests
rgbVec  in  NUM_LAYERS*RGB_W  per-layer colours; layer i at bits [i*RGB_W +: RGB_W]
bgRGB  in  RGB_W  background MIF colour
blinkStart  in  1  pulse that starts or restarts the blink sequence
RGBOut  out  RGB_W  final pixel colour
winLayer  out  3  winning layer index; 5 = background
blinkActive  out  1  high while the blink FSM is not IDLE
playerPixCount  out  17  see Optional Feature

Behaviour:
- Reset values: RGBOut=0, winLayer=5, blinkActive=0, cfgReady=1, playerPixCount=0.
- Reset tables: shadow and active priority table prio[i]=i, all layers enabled. This reproduces the fixed order black > player > roadcars > road > values > background.
- Config write: a write is accepted when cfgWrite && cfgReady. It updates shadow[cfgLayer] with {cfgPrio, cfgEnable} on that edge.
- cfgReady is 0 only in a cycle where startOfFrame=1. A write presented in that cycle is not accepted; the master holds it to the next cycle.
- Commit: on startOfFrame, active table <= shadow table, captured before any same-cycle write.
- Pipeline stage 1: register maskedReq[i] = reqVec[i] && activeEn[i] && !(blinkHide && i==BLINK_LAYER). Register rgbVec and bgRGB alongside.
- Pipeline stage 2: winner is the masked layer with the lowest active prio; ties go to the lowest index. If there is no masked request, the winner is background (winLayer=5, RGBOut=bgRGB). RGBOut and winLayer are registered.
- Latency: exactly 2 clk from inputs to RGBOut/winLayer; throughput 1 pixel/clk.
- The active table changes take effect for inputs sampled on the cycle after the startOfFrame edge.
- Blink FSM states:
  - IDLE: on blinkStart, go to HIDE and set toggle count = 0.
  - HIDE (blinkHide=1): on startOfFrame, go to SHOW and increment count.
  - SHOW: on startOfFrame, go to HIDE and increment count.
  - When count reaches BLINK_TOGGLES on a startOfFrame edge, go to IDLE.
  - blinkStart in HIDE or SHOW restarts: go to HIDE, count=0. blinkStart has priority over a simultaneous startOfFrame.
  - blinkActive = (state != IDLE).
- Reset mid-operation (frame, blink or write) returns all state to reset values immediately.

Optional Feature:
Macro LAYER_SCHED_PIXCOUNT_EN.
- Defined: a 17-bit counter increments each cycle stage 2 selects BLINK_LAYER. It saturates at 17'h1FFFF.
- On startOfFrame, playerPixCount <= counter value (including a same-cycle hit) and the counter clears.
- Not defined: the counter logic is absent and playerPixCount is tied to 0.

Decomposition:
- Package layer_sched_pkg holds:
  - NUM_LAYERS and LAYER_IDX_W=3
  - layer index enum: LYR_BLACK=0, LYR_PLAYER, LYR_ROADCARS, LYR_ROAD, LYR_VALUES, LYR_BG=5
  - blink_state_t {IDLE, HIDE, SHOW}
  - priority-entry struct {prio[2:0], en}
  - default table constant
- Sub-module layer_blink_fsm holds the blink FSM and counter. Its ports are clk, resetN, startOfFrame, blinkStart, blinkHide, blinkActive.

Test Plan:
- Reset, then reqVec=5'b00110 with rgb1=8'h1C, rgb2=8'hE0 -> after 2 clk, RGBOut=8'h1C, winLayer=1.
- Write layer2 prio=0 mid-frame, same reqVec -> output stays 8'h1C until startOfFrame. From inputs sampled after the commit, RGBOut=8'hE0, winLayer=2.
- cfgWrite held on a startOfFrame cycle -> cfgReady=0 and not accepted. Accepted next cycle; the commit in that frame uses the old shadow.
- Disable all layers, reqVec=5'b11111, bgRGB=8'h49 -> RGBOut=8'h49, winLayer=5. Two layers with equal prio=3 -> the lower index wins.
- blinkStart, then 10 frames with reqVec=5'b00010 -> player hidden on frames 1,3,5,7 and background shown. blinkActive drops at the 8th toggle. A blinkStart at frame 4 restarts the count.
- With LAYER_SCHED_PIXCOUNT_EN, player wins 300 pixels in one frame -> playerPixCount=300 after the next startOfFrame. Without the macro -> playerPixCount=0.
